pattern_player_ctrl: RTL and testbench
======================================

PATTERN_PLAYER_CTRL -- requirements
Module: pattern_player_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 10, pattern length in bits (legal range 2..16).
REQ-002 SHALL have port: clock  input  1  system clock (50 MHz).
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: strobe  input  1  one-cycle step tick from the timer.
REQ-005 SHALL have port: start  input  1  level; captures pattern and begins a run.
REQ-006 SHALL have port: abort  input  1  level; terminates a run in progress.
REQ-007 SHALL have port: pattern  input  WIDTH  bit pattern to play, LSB first.
REQ-008 SHALL have port: match  input  1  pattern-detector output, sampled on steps.
REQ-009 SHALL have port: step  output  1  enable to detector FSMs and shift register.
REQ-010 SHALL have port: bit_out  output  1  current pattern bit presented to detectors.
REQ-011 SHALL have port: busy  output  1  high while in RUN.
REQ-012 SHALL have port: done  output  1  run-complete indication.
REQ-013 SHALL have port: bit_index  output  4  index of bit_out within the pattern.
REQ-014 SHALL have port: match_count  output  8  matches counted during the run.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE; busy = (state == RUN); done = (state == DONE).
REQ-016 SHALL, in IDLE or DONE with start=1, capture pattern into play_reg, clear bit_index and match_count, and enter RUN on the next clock.
REQ-017 SHALL ignore start while in RUN.
REQ-018 SHALL drive step = strobe & (state == RUN) & ~abort, combinationally with zero latency.
REQ-019 SHALL drive bit_out = play_reg[0] in all states; bit_out is 0 when play_reg is zero.
REQ-020 SHALL, on each step cycle, shift play_reg right by one (zero fill) and increment bit_index.
REQ-021 SHALL, on each step cycle with match=1, increment match_count, saturating at 255.
REQ-022 SHALL enter DONE on the step cycle with bit_index == WIDTH-1, which makes exactly WIDTH steps per run.
REQ-023 SHALL, in RUN with abort=1, enter IDLE on the next clock with no step; bit_index and match_count hold.
REQ-024 SHALL give abort priority over a coincident strobe.
REQ-025 SHALL hold DONE with match_count stable until start=1.
REQ-026 SHALL ignore strobe and match outside RUN.

Reset
REQ-027 SHALL, while reset_n=0, force state IDLE and clear play_reg, bit_index and match_count, giving step, bit_out, busy and done = 0 asynchronously.
REQ-028 SHALL, on reset mid-run, discard the run; operation resumes only on a new start after release.

Configuration
REQ-029 SHALL support macro PATTERN_PLAYER_LOOP_EN; when it is undefined, behaviour is exactly REQ-015..REQ-026.
REQ-030 SHALL, with PATTERN_PLAYER_LOOP_EN defined, keep a copy of the captured pattern and handle the final step as follows: reload play_reg from the copy, clear bit_index and remain in RUN.
REQ-031 SHALL, with PATTERN_PLAYER_LOOP_EN defined, make done a one-cycle pulse on the clock after each wrap, keep match_count accumulating across wraps (saturating), and enter DONE only via abort, which is then treated as IDLE.

Verification
REQ-032 SHALL verify: reset, then start with pattern=10'b1101101101, strobe every 4 cycles -> bit_out sequence 1,0,1,1,0,1,1,0,1,1; 10 step pulses; done=1 after the 10th step.
REQ-033 SHALL verify: match=1 on steps 3 and 7 only -> match_count=2 in DONE, stable for 20 cycles.
REQ-034 SHALL verify: abort with strobe in the same cycle at bit_index=4 -> step=0 that cycle, IDLE next clock, bit_index=4.
REQ-035 SHALL verify: start pulses while in RUN -> no recapture; the run completes its original 10 bits.
REQ-036 SHALL verify: reset_n low at bit_index=6 -> all outputs 0 immediately; no step until a new start.
REQ-037 SHALL verify: with LOOP_EN, match held at 1 for 30 steps -> done pulses after steps 10, 20 and 30; match_count=30; bit_index wraps 9->0.

Source files
------------

// File: rtl/pattern_player_ctrl.sv
// Pattern player controller: shifts a captured bit pattern out LSB-first, one bit per timer step.
// Optional `PATTERN_PLAYER_LOOP_EN: replay the pattern continuously, pulsing done on each wrap.
module pattern_player_ctrl #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic             match,
  output logic             step,
  output logic             bit_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_index,
  output logic [7:0]       match_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] play_q, play_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             last_step;

`ifdef PATTERN_PLAYER_LOOP_EN
  logic [WIDTH-1:0] copy_q, copy_d;
  logic             wrap_q, wrap_d;
`endif

  // Abort wins over a coincident strobe, so no step is issued on the abort cycle.
  assign step      = strobe & (state_q == StRun) & ~abort;
  assign last_step = (idx_q == 4'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    play_d  = play_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef PATTERN_PLAYER_LOOP_EN
    copy_d  = copy_q;
    wrap_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          play_d  = pattern;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          state_d = StRun;
`ifdef PATTERN_PLAYER_LOOP_EN
          copy_d  = pattern;
`endif
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (strobe) begin
          play_d = play_q >> 1;
          idx_d  = idx_q + 4'd1;
          if (match && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (last_step) begin
`ifdef PATTERN_PLAYER_LOOP_EN
            play_d = copy_q;
            idx_d  = 4'd0;
            wrap_d = 1'b1;
`else
            state_d = StDone;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      play_q  <= '0;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      play_q  <= play_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PATTERN_PLAYER_LOOP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      copy_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      copy_q <= copy_d;
      wrap_q <= wrap_d;
    end
  end

  assign done = wrap_q;
`else
  assign done = (state_q == StDone);
`endif

  assign bit_out     = play_q[0];
  assign busy        = (state_q == StRun);
  assign bit_index   = idx_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_player_ctrl.sv
// Bench for pattern_player_ctrl: directed scenarios plus randomized traffic against a pattern model.
module tb_pattern_player_ctrl;

  localparam int W = 10;
`ifdef PATTERN_PLAYER_LOOP_EN
  localparam bit Loop = 1'b1;
`else
  localparam bit Loop = 1'b0;
`endif

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         strobe  = 1'b0;
  logic         start   = 1'b0;
  logic         abort   = 1'b0;
  logic         match   = 1'b0;
  logic [W-1:0] pattern = '0;
  logic         step, bit_out, busy, done;
  logic [3:0]   bit_index;
  logic [7:0]   match_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: captured pattern, number of bits already played, match tally, run phase.
  int          m_phase;  // 0 idle, 1 run, 2 done
  logic [15:0] m_pat;
  int          m_k;
  int          m_cnt;
  bit          m_pulse;

  pattern_player_ctrl #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .strobe      (strobe),
    .start       (start),
    .abort       (abort),
    .pattern     (pattern),
    .match       (match),
    .step        (step),
    .bit_out     (bit_out),
    .busy        (busy),
    .done        (done),
    .bit_index   (bit_index),
    .match_count (match_count)
  );

  always #10 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0;
    m_pat   = '0;
    m_k     = 0;
    m_cnt   = 0;
    m_pulse = 1'b0;
  endfunction

  function automatic void model_update();
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_pulse = 1'b0;
    if (m_phase != 1) begin
      if (start) begin
        m_pat   = 16'(pattern);
        m_k     = 0;
        m_cnt   = 0;
        m_phase = 1;
      end
    end else if (abort) begin
      m_phase = 0;
    end else if (strobe) begin
      if (match && m_cnt < 255) m_cnt++;
      m_k++;
      if (m_k == W) begin
        if (Loop) begin
          m_k     = 0;
          m_pulse = 1'b1;
        end else begin
          m_phase = 2;
        end
      end
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("step", int'(step), int'(strobe && m_phase == 1 && !abort));
      check("bit_out", int'(bit_out), (m_k < W) ? int'(m_pat[m_k]) : 0);
      check("busy", int'(busy), int'(m_phase == 1));
      check("done", int'(done), Loop ? int'(m_pulse) : int'(m_phase == 2));
      check("bit_index", int'(bit_index), m_k % 16);
      check("match_count", int'(match_count), m_cnt);
    end
  end

  task automatic edge_();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic start_run(input logic [W-1:0] p);
    pattern = p;
    start   = 1'b1;
    edge_();
    start   = 1'b0;
  endtask

`ifdef PATTERN_PLAYER_LOOP_EN
  task automatic loop_test();
    start_run(10'b1101101101);
    match = 1'b1;
    for (int s = 1; s <= 30; s++) begin
      strobe = 1'b1;
      edge_();
      strobe = 1'b0;
      check("loop_done_pulse", int'(done), int'(s % 10 == 0));
      check("loop_index", int'(bit_index), s % 10);
      edge_();
      check("loop_done_one_cycle", int'(done), 0);
    end
    check("loop_match_count", int'(match_count), 30);
    check("loop_busy", int'(busy), 1);
    match = 1'b0;
    abort = 1'b1;
    edge_();
    abort = 1'b0;
    check("loop_abort_busy", int'(busy), 0);
    check("loop_abort_done", int'(done), 0);
  endtask
`else
  task automatic directed_tests();
    logic exp_bits [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] pat_a = 10'b0000011111;
    logic [W-1:0] pat_b = 10'b1111100000;
    logic got [16];
    int nstep;
    int seen;

    // Basic run: strobe every 4 cycles, matches on steps 3 and 7.
    start_run(10'b1101101101);
    nstep = 0;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      strobe = (i % 4 == 3);
      match  = strobe && (nstep == 2 || nstep == 6);
      #1;
      if (step) seen++;
      if (strobe) begin
        got[nstep] = bit_out;
        nstep++;
      end
      edge_();
    end
    strobe = 1'b0;
    match  = 1'b0;
    for (int i = 0; i < 10; i++) check("run_bit_seq", int'(got[i]), int'(exp_bits[i]));
    check("run_step_count", seen, 10);
    check("run_done", int'(done), 1);
    check("run_busy", int'(busy), 0);
    check("run_match_count", int'(match_count), 2);
    check("run_final_index", int'(bit_index), 10);
    for (int i = 0; i < 20; i++) begin
      strobe = i[0];
      match  = 1'b1;
      edge_();
      check("done_hold_count", int'(match_count), 2);
      check("done_hold_flag", int'(done), 1);
    end
    strobe = 1'b0;
    match  = 1'b0;

    // Abort coincident with strobe at bit_index 4.
    start_run(10'b1010110011);
    for (int j = 0; j < 4; j++) begin
      strobe = 1'b1;
      edge_();
      strobe = 1'b0;
      edge_();
    end
    check("pre_abort_index", int'(bit_index), 4);
    strobe = 1'b1;
    abort  = 1'b1;
    #1;
    check("abort_step", int'(step), 0);
    edge_();
    strobe = 1'b0;
    abort  = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_index", int'(bit_index), 4);

    // Start pulses during a run must not recapture.
    start_run(pat_a);
    nstep = 0;
    for (int i = 0; i < 30; i++) begin
      strobe  = (i % 3 == 2);
      start   = (i % 5 == 1);
      pattern = i[0] ? pat_b : pat_a;
      #1;
      if (strobe) begin
        got[nstep] = bit_out;
        nstep++;
      end
      edge_();
    end
    strobe = 1'b0;
    start  = 1'b0;
    for (int i = 0; i < 10; i++) check("norecapture_bit", int'(got[i]), int'(pat_a[i]));
    check("norecapture_done", int'(done), 1);

    // Reset mid-run at bit_index 6.
    start_run(10'b1111111111);
    for (int j = 0; j < 6; j++) begin
      strobe = 1'b1;
      edge_();
    end
    check("pre_reset_index", int'(bit_index), 6);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_step", int'(step), 0);
    check("rst_bit_out", int'(bit_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_index", int'(bit_index), 0);
    check("rst_count", int'(match_count), 0);
    edge_();
    reset_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("post_rst_no_step", int'(step), 0);
      edge_();
    end
    strobe = 1'b0;
  endtask
`endif

  initial begin
    model_reset();
    strobe = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_step", int'(step), 0);
    check("reset_bit_out", int'(bit_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_index", int'(bit_index), 0);
    check("reset_count", int'(match_count), 0);
    strobe  = 1'b0;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    edge_();

`ifdef PATTERN_PLAYER_LOOP_EN
    loop_test();
`else
    directed_tests();
`endif

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      strobe  = ($urandom_range(0, 2) == 0);
      start   = ($urandom_range(0, 11) == 0);
      abort   = ($urandom_range(0, 29) == 0);
      match   = $urandom_range(0, 1) == 1;
      pattern = W'($urandom);
      edge_();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
